// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
//   Shared definitions for the branch predictor:
//     - ctr_t      : 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//     - ctr_inc    : saturating increment (ST holds)
//     - ctr_dec    : saturating decrement (SNT holds)
//     - ctr_taken  : counter says "predict taken" (WT or ST)
//     - bp_tag_w   : tag width left over once the index and pc[1:0] are removed
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam int BP_PC_W = 32;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  // Tag = pc[31:idx_w+2]; pc[1:0] is always ignored.
  function automatic int bp_tag_w(input int idx_w);
    return BP_PC_W - idx_w - 2;
  endfunction

  function automatic ctr_t ctr_inc(input ctr_t c);
    case (c)
      SNT:     return WNT;
      WNT:     return WT;
      default: return ST;
    endcase
  endfunction

  function automatic ctr_t ctr_dec(input ctr_t c);
    case (c)
      ST:      return WT;
      WT:      return WNT;
      default: return SNT;
    endcase
  endfunction

  function automatic logic ctr_taken(input ctr_t c);
    return (c == WT) || (c == ST);
  endfunction

endpackage

// File: rtl/branch_predictor_table.sv
// -----------------------------------------------------------------------------
// branch_predictor_table
//   Direct-mapped BTB storage: per entry a valid bit, tag, 32-bit target and a
//   2-bit saturating counter. One combinational read port for fetch-time lookup
//   and one synchronous update port that performs the retire-time
//   read-modify-write of a single entry.
//
// Ports
//   clk        in   core clock
//   reset      in   synchronous, active-high; clears every entry
//   rd_idx     in   lookup index
//   rd_valid   out  valid bit at rd_idx
//   rd_tag     out  tag at rd_idx
//   rd_target  out  stored target at rd_idx
//   rd_ctr     out  counter at rd_idx
//   wr_en      in   apply an update at the next posedge
//   wr_idx     in   entry to update
//   wr_tag     in   tag of the resolved branch
//   wr_taken   in   resolved direction
//   wr_target  in   resolved taken target
//
// The read port always shows the pre-update contents: a same-cycle update of
// the same entry becomes visible only after the clock edge.
// -----------------------------------------------------------------------------
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int TAG_W   = bp_tag_w(IDX_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [31:0]       rd_target,
  output ctr_t              rd_ctr,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic              wr_taken,
  input  logic [31:0]       wr_target
);

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  ctr_t             ctr_q    [ENTRIES];

  logic wr_hit;

  assign rd_valid  = valid_q[rd_idx];
  assign rd_tag    = tag_q[rd_idx];
  assign rd_target = target_q[rd_idx];
  assign rd_ctr    = ctr_q[rd_idx];

  always_comb begin
    wr_hit = 1'b0;
    wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
  end

  // Hit: train the counter, refresh the target on taken.
  // Miss + taken: allocate as weakly-taken, evicting whatever lived there.
  // Miss + not-taken: leave the entry alone so a cold branch does not evict.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= WNT;
      end
    end else if (wr_en) begin
      if (wr_hit) begin
        if (wr_taken) begin
          ctr_q[wr_idx]    <= ctr_inc(ctr_q[wr_idx]);
          target_q[wr_idx] <= wr_target;
        end else begin
          ctr_q[wr_idx]    <= ctr_dec(ctr_q[wr_idx]);
        end
      end else if (wr_taken) begin
        valid_q[wr_idx]  <= 1'b1;
        tag_q[wr_idx]    <= wr_tag;
        target_q[wr_idx] <= wr_target;
        ctr_q[wr_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//   Dynamic branch predictor for the PC controller: direct-mapped BTB with a
//   2-bit saturating counter per entry.
//
// Configuration macro: BP_GSHARE_EN
//   defined   : an IDX_W-bit global history register is XORed into the index
//               and shifted on every retired conditional branch.
//   undefined : index = if_pc[IDX_W+1:2], no history flops.
//
// Ports
//   clk                     in   core clock
//   reset                   in   synchronous, active-high
//   if_pc                   in   fetch PC
//   branch_estimation       out  predict taken for if_pc
//   branch_target           out  predicted target (if_pc+4 on a tag miss)
//   if_bp_index             out  table index used for if_pc
//   ex_valid                in   EX instruction valid
//   ex_is_branch            in   EX instruction is a conditional branch
//   ex_pc                   in   EX PC
//   ex_bp_index             in   index carried down from fetch
//   ex_pred_taken           in   prediction carried down from fetch
//   ex_pred_target          in   predicted target carried down from fetch
//   ex_taken                in   resolved direction
//   ex_target               in   resolved taken target
//   branch_prediction_miss  out  EX branch was mispredicted
//   branch_target_actual    out  redirect PC: ex_taken ? ex_target : ex_pc+4
//
// EX qualification: ex_valid is a single-cycle "this branch retires now"
// strobe with no back-pressure. The pipeline holds ex_* stable across stalls
// and drops ex_valid on repeated cycles, so each branch trains the table once.
// ENTRIES must be a power of two and at least 4.
// -----------------------------------------------------------------------------
module branch_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 64,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       if_pc,
  output logic              branch_estimation,
  output logic [31:0]       branch_target,
  output logic [IDX_W-1:0]  if_bp_index,
  input  logic              ex_valid,
  input  logic              ex_is_branch,
  input  logic [31:0]       ex_pc,
  input  logic [IDX_W-1:0]  ex_bp_index,
  input  logic              ex_pred_taken,
  input  logic [31:0]       ex_pred_target,
  input  logic              ex_taken,
  input  logic [31:0]       ex_target,
  output logic              branch_prediction_miss,
  output logic [31:0]       branch_target_actual
);

  localparam int TAG_W = bp_tag_w(IDX_W);

  logic              upd;
  logic [IDX_W-1:0]  pc_idx;
  logic [TAG_W-1:0]  if_tag;
  logic [TAG_W-1:0]  ex_tag;
  logic              rd_valid;
  logic [TAG_W-1:0]  rd_tag;
  logic [31:0]       rd_target;
  ctr_t              rd_ctr;
  logic              lookup_hit;
  logic [31:0]       ex_fallthrough;

  assign upd    = ex_valid && ex_is_branch && !reset;
  assign pc_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[31:IDX_W+2];
  assign ex_tag = ex_pc[31:IDX_W+2];

`ifdef BP_GSHARE_EN
  // History is updated at retire only (non-speculative), so fetch and retire
  // may see different histories; the index travels with the instruction to
  // keep the update pointed at the entry that made the prediction.
  logic [IDX_W-1:0] ghr;

  always_ff @(posedge clk) begin
    if (reset) begin
      ghr <= '0;
    end else if (upd) begin
      ghr <= {ghr[IDX_W-2:0], ex_taken};
    end
  end

  assign if_bp_index = pc_idx ^ ghr;
`else
  assign if_bp_index = pc_idx;
`endif

  branch_predictor_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W),
    .TAG_W   (TAG_W)
  ) u_table (
    .clk       (clk),
    .reset     (reset),
    .rd_idx    (if_bp_index),
    .rd_valid  (rd_valid),
    .rd_tag    (rd_tag),
    .rd_target (rd_target),
    .rd_ctr    (rd_ctr),
    .wr_en     (upd),
    .wr_idx    (ex_bp_index),
    .wr_tag    (ex_tag),
    .wr_taken  (ex_taken),
    .wr_target (ex_target)
  );

  // Fetch-side lookup. The estimate is forced low during reset because the
  // table is only cleared at the reset edge.
  always_comb begin
    lookup_hit        = 1'b0;
    branch_estimation = 1'b0;
    branch_target     = '0;
    lookup_hit        = rd_valid && (rd_tag == if_tag);
    branch_estimation = !reset && lookup_hit && ctr_taken(rd_ctr);
    branch_target     = lookup_hit ? rd_target : (if_pc + 32'd4);
  end

  // EX-side resolution. The redirect PC is always driven; the miss flag only
  // fires for a qualified conditional branch. A taken branch whose predicted
  // target differs is a miss even when the direction was right.
  always_comb begin
    ex_fallthrough         = '0;
    branch_target_actual   = '0;
    branch_prediction_miss = 1'b0;
    ex_fallthrough         = ex_pc + 32'd4;
    branch_target_actual   = ex_taken ? ex_target : ex_fallthrough;
    branch_prediction_miss = upd &&
                             ((ex_pred_taken != ex_taken) ||
                              (ex_taken && (ex_pred_target != ex_target)));
  end

endmodule

// File: tb/tb_branch_predictor.sv
`timescale 1ns/1ps
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int IDX_W   = 6;
  localparam int TAG_SH  = IDX_W + 2;
  localparam int W       = 1 + 32 + IDX_W + 1 + 32;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              reset;
  logic [31:0]       if_pc;
  logic              branch_estimation;
  logic [31:0]       branch_target;
  logic [IDX_W-1:0]  if_bp_index;
  logic              ex_valid;
  logic              ex_is_branch;
  logic [31:0]       ex_pc;
  logic [IDX_W-1:0]  ex_bp_index;
  logic              ex_pred_taken;
  logic [31:0]       ex_pred_target;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic              branch_prediction_miss;
  logic [31:0]       branch_target_actual;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .if_pc                  (if_pc),
    .branch_estimation      (branch_estimation),
    .branch_target          (branch_target),
    .if_bp_index            (if_bp_index),
    .ex_valid               (ex_valid),
    .ex_is_branch           (ex_is_branch),
    .ex_pc                  (ex_pc),
    .ex_bp_index            (ex_bp_index),
    .ex_pred_taken          (ex_pred_taken),
    .ex_pred_target         (ex_pred_target),
    .ex_taken               (ex_taken),
    .ex_target              (ex_target),
    .branch_prediction_miss (branch_prediction_miss),
    .branch_target_actual   (branch_target_actual)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // ---------------- reference model ----------------
  // Plain arrays; counter kept as an integer 0..3 (>=2 means predict taken).
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_ghr;

  task automatic m_clear();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_ctr[i]   = 1;
    end
    m_ghr = 0;
  endtask

  task automatic m_update();
    int          i;
    logic [31:0] t;
    i = int'(ex_bp_index);
    t = ex_pc >> TAG_SH;
    if (m_valid[i] && m_tag[i] == t) begin
      if (ex_taken) begin
        if (m_ctr[i] < 3) m_ctr[i] = m_ctr[i] + 1;
        m_tgt[i] = ex_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i] = m_ctr[i] - 1;
      end
    end else if (ex_taken) begin
      m_valid[i] = 1'b1;
      m_tag[i]   = t;
      m_tgt[i]   = ex_target;
      m_ctr[i]   = 2;
    end
`ifdef BP_GSHARE_EN
    m_ghr = ((m_ghr * 2) + (ex_taken ? 1 : 0)) % ENTRIES;
`endif
  endtask

  always @(posedge clk) begin
    if (reset) m_clear();
    else if (ex_valid && ex_is_branch) m_update();
  end

  function automatic logic [IDX_W-1:0] m_idx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % ENTRIES);
`ifdef BP_GSHARE_EN
    i = i ^ m_ghr;
`endif
    return IDX_W'(i);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = int'(m_idx(pc));
    return m_valid[i] && (m_tag[i] == (pc >> TAG_SH));
  endfunction

  function automatic logic exp_est(input logic [31:0] pc);
    return !reset && m_hit(pc) && (m_ctr[int'(m_idx(pc))] >= 2);
  endfunction

  function automatic logic [31:0] exp_tgt(input logic [31:0] pc);
    return m_hit(pc) ? m_tgt[int'(m_idx(pc))] : pc + 32'd4;
  endfunction

  function automatic logic exp_miss();
    return (ex_valid && ex_is_branch && !reset) &&
           ((ex_pred_taken != ex_taken) || (ex_taken && ex_pred_target != ex_target));
  endfunction

  function automatic logic [31:0] exp_actual();
    return ex_taken ? ex_target : ex_pc + 32'd4;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ex();
    ex_valid       = 1'b0;
    ex_is_branch   = 1'b0;
    ex_pc          = '0;
    ex_bp_index    = '0;
    ex_pred_taken  = 1'b0;
    ex_pred_target = '0;
    ex_taken       = 1'b0;
    ex_target      = '0;
  endtask

  // Retire a branch; prediction fields default to what the model predicts.
  task automatic drive_branch(input logic [31:0] pc, input logic taken,
                              input logic [31:0] tgt);
    ex_valid       = 1'b1;
    ex_is_branch   = 1'b1;
    ex_pc          = pc;
    ex_bp_index    = m_idx(pc);
    ex_pred_taken  = exp_est(pc);
    ex_pred_target = exp_tgt(pc);
    ex_taken       = taken;
    ex_target      = tgt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] pc;
    reset = 1'b1;
    idle_ex();
    if_pc = 32'h100;
    repeat (3) tick();
    // Branch presented while reset is high: no miss, no estimate, discarded.
    drive_branch(32'h100, 1'b1, 32'h80);
    ex_pred_taken = 1'b0;
    #1;
    checks++;
    if (branch_estimation !== 1'b0) begin
      errors++; $display("FAIL reset_est: got %b expected 0", branch_estimation);
    end
    checks++;
    if (branch_prediction_miss !== 1'b0) begin
      errors++; $display("FAIL reset_miss: got %b expected 0", branch_prediction_miss);
    end
    tick();
    reset = 1'b0;
    idle_ex();
    for (int k = 0; k < 4; k++) begin
      pc = (k == 0) ? 32'h100 : $urandom();
      if_pc = pc;
      #1;
      checks++;
      if (branch_estimation !== 1'b0 || branch_target !== pc + 32'd4 ||
          branch_prediction_miss !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_lookup pc=%h: got est=%b tgt=%h miss=%b expected est=0 tgt=%h miss=0",
                 pc, branch_estimation, branch_target, branch_prediction_miss, pc + 32'd4);
      end
    end
  endtask

  task automatic test_alloc();
    if_pc = 32'h100;
    drive_branch(32'h100, 1'b1, 32'h80);
    #1;
    checks++;
    if (branch_prediction_miss !== 1'b1 || branch_target_actual !== 32'h80) begin
      errors++;
      $display("FAIL alloc_miss: got miss=%b actual=%h expected miss=1 actual=00000080",
               branch_prediction_miss, branch_target_actual);
    end
    tick();
    idle_ex();
    #1;
    checks++;
    if (branch_estimation !== exp_est(32'h100) || branch_target !== exp_tgt(32'h100)) begin
      errors++;
      $display("FAIL alloc_lookup: got est=%b tgt=%h expected est=%b tgt=%h",
               branch_estimation, branch_target, exp_est(32'h100), exp_tgt(32'h100));
    end
`ifndef BP_GSHARE_EN
    checks++;
    if (branch_estimation !== 1'b1 || branch_target !== 32'h80) begin
      errors++;
      $display("FAIL alloc_lookup_const: got est=%b tgt=%h expected est=1 tgt=00000080",
               branch_estimation, branch_target);
    end
`endif
  endtask

  task automatic test_not_taken_decay();
    for (int k = 0; k < 3; k++) begin
      if_pc = 32'h100;
      drive_branch(32'h100, 1'b0, 32'h80);
      #1;
      checks++;
      if (branch_prediction_miss !== exp_miss() || branch_target_actual !== 32'h104) begin
        errors++;
        $display("FAIL decay_ex[%0d]: got miss=%b actual=%h expected miss=%b actual=00000104",
                 k, branch_prediction_miss, branch_target_actual, exp_miss());
      end
      tick();
      idle_ex();
      #1;
      checks++;
      if (branch_estimation !== exp_est(32'h100)) begin
        errors++;
        $display("FAIL decay_lookup[%0d]: got est=%b expected %b",
                 k, branch_estimation, exp_est(32'h100));
      end
    end
`ifndef BP_GSHARE_EN
    checks++;
    if (branch_estimation !== 1'b0 || m_ctr[int'(m_idx(32'h100))] != 0) begin
      errors++;
      $display("FAIL decay_floor: got est=%b expected est=0 with counter at 00",
               branch_estimation);
    end
`endif
  endtask

  task automatic test_alias();
    logic [31:0] pc2;
    pc2 = 32'h100 + 32'(4 * ENTRIES);
    drive_branch(32'h100, 1'b1, 32'h80);
    tick();
    idle_ex();
    if_pc = pc2;
    #1;
    checks++;
    if (branch_estimation !== exp_est(pc2) || branch_target !== exp_tgt(pc2)) begin
      errors++;
      $display("FAIL alias_lookup: got est=%b tgt=%h expected est=%b tgt=%h",
               branch_estimation, branch_target, exp_est(pc2), exp_tgt(pc2));
    end
    drive_branch(pc2, 1'b1, 32'h200);
    tick();
    idle_ex();
    #1;
    checks++;
    if (branch_estimation !== exp_est(pc2) || branch_target !== exp_tgt(pc2)) begin
      errors++;
      $display("FAIL alias_realloc: got est=%b tgt=%h expected est=%b tgt=%h",
               branch_estimation, branch_target, exp_est(pc2), exp_tgt(pc2));
    end
    if_pc = 32'h100;
    #1;
    checks++;
    if (branch_estimation !== exp_est(32'h100) || branch_target !== exp_tgt(32'h100)) begin
      errors++;
      $display("FAIL alias_evicted: got est=%b tgt=%h expected est=%b tgt=%h",
               branch_estimation, branch_target, exp_est(32'h100), exp_tgt(32'h100));
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] pc;
    pc = 32'h3C0;
    drive_branch(pc, 1'b1, 32'h40);   // fresh allocation, weakly taken
    tick();
    if_pc = pc;
    drive_branch(pc, 1'b0, 32'h40);   // lookup and update the same entry
    #1;
    checks++;
    if (branch_estimation !== exp_est(pc) || branch_target !== exp_tgt(pc)) begin
      errors++;
      $display("FAIL same_cycle_old: got est=%b tgt=%h expected est=%b tgt=%h",
               branch_estimation, branch_target, exp_est(pc), exp_tgt(pc));
    end
    tick();
    idle_ex();
    #1;
    checks++;
    if (branch_estimation !== exp_est(pc)) begin
      errors++;
      $display("FAIL same_cycle_new: got est=%b expected %b", branch_estimation, exp_est(pc));
    end
  endtask

  task automatic test_non_branch();
    if_pc = 32'hFFFF_FFFC;
    drive_branch(32'hFFFF_FFFC, 1'b0, 32'h10);
    ex_is_branch  = 1'b0;
    ex_pred_taken = 1'b1;
    #1;
    checks++;
    if (branch_prediction_miss !== 1'b0 || branch_target_actual !== 32'h0) begin
      errors++;
      $display("FAIL non_branch: got miss=%b actual=%h expected miss=0 actual=00000000",
               branch_prediction_miss, branch_target_actual);
    end
    ex_is_branch = 1'b1;
    ex_valid     = 1'b0;
    ex_taken     = 1'b1;
    #1;
    checks++;
    if (branch_prediction_miss !== 1'b0 || branch_target_actual !== 32'h10) begin
      errors++;
      $display("FAIL invalid_ex: got miss=%b actual=%h expected miss=0 actual=00000010",
               branch_prediction_miss, branch_target_actual);
    end
    tick();
    idle_ex();
    #1;
    checks++;
    if (branch_estimation !== exp_est(32'hFFFF_FFFC) || branch_target !== 32'h0) begin
      errors++;
      $display("FAIL non_branch_nowrite: got est=%b tgt=%h expected est=%b tgt=00000000",
               branch_estimation, branch_target, exp_est(32'hFFFF_FFFC));
    end
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    logic [31:0] pc;
    logic [IDX_W-1:0] base;
    reset = 1'b1;
    idle_ex();
    tick();
    reset = 1'b0;
    drive_branch(32'h100, 1'b1, 32'h80); tick();
    drive_branch(32'h100, 1'b1, 32'h80); tick();
    drive_branch(32'h100, 1'b0, 32'h80); tick();
    idle_ex();
    pc   = 32'h1234_5678;
    base = IDX_W'(pc >> 2);
    if_pc = pc;
    #1;
    checks++;
    if (if_bp_index !== (base ^ 6'b110)) begin
      errors++;
      $display("FAIL gshare_ttn: got idx=%h expected %h", if_bp_index, base ^ 6'b110);
    end
    drive_branch(32'h100, 1'b1, 32'h80);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle_ex();
    #1;
    checks++;
    if (if_bp_index !== base) begin
      errors++;
      $display("FAIL gshare_reset: got idx=%h expected %h", if_bp_index, base);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] pool [8];
    logic [31:0] tgts [4];
    logic [W-1:0] got;
    logic [W-1:0] exp;
    pool = '{32'h100, 32'h104, 32'h108, 32'h200, 32'h300, 32'h2000, 32'h1F0, 32'hFFFF_FFFC};
    tgts = '{32'h80, 32'h200, 32'h1000, 32'hFFFF_FFF0};
    for (int cyc = 0; cyc < 400; cyc++) begin
      reset = ($urandom_range(0, 59) == 0);
      if_pc = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      drive_branch(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                   tgts[$urandom_range(0, 3)]);
      ex_valid     = ($urandom_range(0, 7) != 0);
      ex_is_branch = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = tgts[$urandom_range(0, 3)];
      end
      if ($urandom_range(0, 9) == 0) ex_bp_index = IDX_W'($urandom_range(0, ENTRIES - 1));
      #1;
      exp_q.push_back({exp_est(if_pc), exp_tgt(if_pc), m_idx(if_pc), exp_miss(), exp_actual()});
      got = {branch_estimation, branch_target, if_bp_index, branch_prediction_miss,
             branch_target_actual};
      exp = exp_q.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] {est,tgt,idx,miss,actual}: got %h expected %h", cyc, got, exp);
      end
      tick();
    end
    reset = 1'b0;
    idle_ex();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    reset = 1'b1;
    if_pc = '0;
    idle_ex();
    m_clear();
    test_reset();
    test_alloc();
    test_not_taken_decay();
    test_alias();
    test_same_cycle();
    test_non_branch();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
